// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU defaults and the register-index type
package cpu_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int NREGS_DEF = 8;
    localparam logic [15:0] R0_INIT_DEF = 16'h0001;
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the register file
interface regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int NREGS = 8
);
    localparam int ADDR_W = $clog2(NREGS);
    logic write_en;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] writedata;
    logic [ADDR_W-1:0] rega;
    logic [ADDR_W-1:0] regb;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;
    logic busy1;
    logic busy2;
    logic claim_en;
    logic [ADDR_W-1:0] claim_reg;
    logic [ADDR_W:0] busy_cnt;
    logic err_wb;
    modport master (
        output write_en, wreg, writedata, rega, regb, claim_en, claim_reg,
        input read1, read2, busy1, busy2, busy_cnt, err_wb
    );
    modport slave (
        input write_en, wreg, writedata, rega, regb, claim_en, claim_reg,
        output read1, read2, busy1, busy2, busy_cnt, err_wb
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, busy count and sticky writeback error
module regfile_scoreboard #(
    parameter int NREGS = 8,
    parameter int ADDR_W = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] wreg,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_reg,
    output logic [NREGS-1:0]  busy,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              err_wb
);
    logic [NREGS-1:0] busy_nxt;
    logic [ADDR_W:0] cnt_nxt;
    logic err_set;
    // a claim beats a same-cycle release so the newer producer keeps the register
    always_comb begin
        busy_nxt = busy;
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_nxt[i] = (claim_en && claim_reg == ADDR_W'(i) && !(ZERO_REG && i == 0)) ? 1'b1 :
                          (write_en && wreg == ADDR_W'(i)) ? 1'b0 : busy[i];
            cnt_nxt = cnt_nxt + (ADDR_W + 1)'(busy_nxt[i]);
        end
    end
    assign err_set = write_en && !busy[wreg] && !(ZERO_REG && wreg == '0);
    // busy_cnt tracks the popcount of the bits being registered alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            busy_cnt <= '0;
            err_wb <= 1'b0;
        end else begin
            busy <= busy_nxt;
            busy_cnt <= cnt_nxt;
            err_wb <= err_wb | err_set;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with bypass, optional zero register and scoreboard
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int ADDR_W = $clog2(NREGS),
    parameter logic [DATA_W-1:0] R0_INIT = DATA_W'(R0_INIT_DEF),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS = 1'b1
) (
    input logic clk,
    input logic rst,
    regfile_sb_if.slave bus
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic wr_ok;
    assign wr_ok = bus.write_en && !(ZERO_REG && bus.wreg == '0);
    // data array; register 0 is left untouched when it is hardwired to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == 0 && !ZERO_REG) ? R0_INIT : '0;
        end else if (wr_ok) begin
            regs[bus.wreg] <= bus.writedata;
        end
    end
    assign bus.read1 = (BYPASS && wr_ok && bus.wreg == bus.rega) ? bus.writedata : regs[bus.rega];
    assign bus.read2 = (BYPASS && wr_ok && bus.wreg == bus.regb) ? bus.writedata : regs[bus.regb];
    assign bus.busy1 = busy[bus.rega];
    assign bus.busy2 = busy[bus.regb];
    regfile_scoreboard #(
        .NREGS(NREGS),
        .ADDR_W(ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk(clk),
        .rst(rst),
        .write_en(bus.write_en),
        .wreg(bus.wreg),
        .claim_en(bus.claim_en),
        .claim_reg(bus.claim_reg),
        .busy(busy),
        .busy_cnt(bus.busy_cnt),
        .err_wb(bus.err_wb)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of three register-file configurations driven in lockstep
module tb_regfile_sb;
    import cpu_pkg::*;
    logic clk;
    logic rst;
    logic write_en;
    reg_idx_t wreg;
    logic [15:0] writedata;
    reg_idx_t rega;
    reg_idx_t regb;
    logic claim_en;
    reg_idx_t claim_reg;
    int total;
    int bad;

    regfile_sb_if #(.DATA_W(16), .NREGS(8)) ia ();
    regfile_sb_if #(.DATA_W(16), .NREGS(8)) ib ();
    regfile_sb_if #(.DATA_W(16), .NREGS(8)) ic ();

    assign {ia.write_en, ia.wreg, ia.writedata, ia.rega, ia.regb, ia.claim_en, ia.claim_reg} =
           {write_en, wreg, writedata, rega, regb, claim_en, claim_reg};
    assign {ib.write_en, ib.wreg, ib.writedata, ib.rega, ib.regb, ib.claim_en, ib.claim_reg} =
           {write_en, wreg, writedata, rega, regb, claim_en, claim_reg};
    assign {ic.write_en, ic.wreg, ic.writedata, ic.rega, ic.regb, ic.claim_en, ic.claim_reg} =
           {write_en, wreg, writedata, rega, regb, claim_en, claim_reg};

    regfile_sb #(.BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    regfile_sb #(.BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    regfile_sb #(.BYPASS(1'b1), .ZERO_REG(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        write_en = 1'b0;
        wreg = '0;
        writedata = '0;
        rega = '0;
        regb = 3'd7;
        claim_en = 1'b0;
        claim_reg = '0;
        #12;
        rst = 1'b0;
        #1;
        chk("rst_r0_a", ia.read1, 16'h0001);
        chk("rst_r0_c", ic.read1, 16'h0000);
        chk("rst_r7_a", ia.read2, 16'h0000);
        chk("rst_cnt_a", ia.busy_cnt, 0);
        chk("rst_err_a", ia.err_wb, 0);
        // claim r5, then release it with a write
        claim_en = 1'b1; claim_reg = 3'd5; rega = 3'd5;
        #1;
        chk("pre_claim_busy1", ia.busy1, 0);
        tick();
        claim_en = 1'b0;
        chk("claim_busy1", ia.busy1, 1);
        chk("claim_cnt", ia.busy_cnt, 1);
        write_en = 1'b1; wreg = 3'd5; writedata = 16'h1234;
        #1;
        chk("wb5_byp_a", ia.read1, 16'h1234);
        chk("wb5_nobyp_b", ib.read1, 16'h0000);
        tick();
        write_en = 1'b0;
        #1;
        chk("rel_busy1", ia.busy1, 0);
        chk("rel_cnt", ia.busy_cnt, 0);
        chk("rel_read_a", ia.read1, 16'h1234);
        chk("rel_read_b", ib.read1, 16'h1234);
        chk("rel_err", ia.err_wb, 0);
        // r2 claimed, then claimed again while being written
        claim_en = 1'b1; claim_reg = 3'd2; regb = 3'd2;
        tick();
        write_en = 1'b1; wreg = 3'd2; writedata = 16'h00AA;
        tick();
        write_en = 1'b0; claim_en = 1'b0;
        #1;
        chk("sim_busy2", ia.busy2, 1);
        chk("sim_cnt", ia.busy_cnt, 1);
        chk("sim_read2", ia.read2, 16'h00AA);
        chk("sim_err", ia.err_wb, 0);
        // bypass vs no bypass on r3 (claimed first so the write is legal)
        claim_en = 1'b1; claim_reg = 3'd3;
        tick();
        claim_en = 1'b0;
        write_en = 1'b1; wreg = 3'd3; writedata = 16'hBEEF; rega = 3'd3;
        #1;
        chk("byp_a", ia.read1, 16'hBEEF);
        chk("nobyp_b_old", ib.read1, 16'h0000);
        tick();
        write_en = 1'b0;
        #1;
        chk("nobyp_b_new", ib.read1, 16'hBEEF);
        chk("byp_cnt", ib.busy_cnt, 1);
        chk("byp_err", ib.err_wb, 0);
        // unclaimed writeback to r6 sets the sticky error
        write_en = 1'b1; wreg = 3'd6; writedata = 16'h0066; rega = 3'd6;
        tick();
        write_en = 1'b0;
        #1;
        chk("err_set", ia.err_wb, 1);
        chk("err_r6_b", ib.read1, 16'h0066);
        claim_en = 1'b1; claim_reg = 3'd4;
        tick();
        claim_en = 1'b0;
        write_en = 1'b1; wreg = 3'd4; writedata = 16'h0044;
        tick();
        write_en = 1'b0;
        #1;
        chk("err_sticky", ia.err_wb, 1);
        chk("err_sticky_cnt", ia.busy_cnt, 1);
        // asynchronous reset mid-cycle with dirty state
        rega = 3'd0; regb = 3'd2;
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_r0", ia.read1, 16'h0001);
        chk("mrst_r2", ia.read2, 16'h0000);
        chk("mrst_busy2", ia.busy2, 0);
        chk("mrst_cnt", ia.busy_cnt, 0);
        chk("mrst_err", ia.err_wb, 0);
        chk("mrst_r2_b", ib.read2, 16'h0000);
        tick();
        rst = 1'b0;
        // zero register: write and claim r0 together
        write_en = 1'b1; wreg = 3'd0; writedata = 16'hFFFF; claim_en = 1'b1; claim_reg = 3'd0; rega = 3'd0;
        #1;
        chk("z_byp_c", ic.read1, 16'h0000);
        tick();
        write_en = 1'b0; claim_en = 1'b0;
        #1;
        chk("z_read_c", ic.read1, 16'h0000);
        chk("z_busy_c", ic.busy1, 0);
        chk("z_cnt_c", ic.busy_cnt, 0);
        chk("z_err_c", ic.err_wb, 0);
        chk("nz_read_a", ia.read1, 16'hFFFF);
        chk("nz_busy_a", ia.busy1, 1);
        chk("nz_err_a", ia.err_wb, 1);
        // claim every other register
        for (int i = 1; i < 8; i++) begin
            claim_en = 1'b1;
            claim_reg = reg_idx_t'(i);
            tick();
        end
        claim_en = 1'b0;
        #1;
        chk("fill_cnt_c", ic.busy_cnt, 7);
        chk("fill_cnt_a", ia.busy_cnt, 8);
        chk("fill_err_c", ic.err_wb, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 8x16 register file.
- Generalises data width and register count, and adds optional write-through bypass, an optional hardwired zero register and a per-register busy scoreboard for the pipelined core.
- Sits between decode (reads and claims destination registers) and writeback (writes data, releases claims).
- Also reports a busy-register count and a sticky protocol-error flag.

Parameters:
DATA_W, 16, register data width in bits
NREGS, 8, number of registers (power of two, at least 2)
ADDR_W, $clog2(NREGS), register index width (derived, do not override)
R0_INIT, 16'h0001, reset value of register 0 (ignored when ZERO_REG=1)
ZERO_REG, 0, 1 = register 0 reads as 0, is never written and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to the read ports

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
write_en  in  1  writeback strobe
wreg  in  ADDR_W  writeback register index
writedata  in  DATA_W  writeback data
rega  in  ADDR_W  read port 1 index
regb  in  ADDR_W  read port 2 index
read1  out  DATA_W  read port 1 data (combinational)
read2  out  DATA_W  read port 2 data (combinational)
busy1  out  1  scoreboard bit of rega (combinational)
busy2  out  1  scoreboard bit of regb (combinational)
claim_en  in  1  decode claims a destination register
claim_reg  in  ADDR_W  register being claimed
busy_cnt  out  ADDR_W+1  number of busy registers (registered)
err_wb  out  1  sticky: writeback to a register that was not busy

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - reg[0] = R0_INIT, or 0 when ZERO_REG=1; all other registers = 0.
  - All busy bits = 0; busy_cnt = 0; err_wb = 0.
  - Reads during reset return the reset values.
- Write: on posedge clk with write_en, reg[wreg] <= writedata.
  - With ZERO_REG=1 and wreg=0, the write is discarded.
- Read: combinational from rega and regb.
  - With BYPASS=1, write_en, wreg==rega and the write not discarded: read1 = writedata. read2 likewise.
  - BYPASS=0: reads return the stored value; new data is visible the cycle after the write.
- Scoreboard, per register, evaluated on posedge clk:
  - claim_en && claim_reg==i sets busy[i].
  - write_en && wreg==i clears busy[i].
  - Both in the same cycle on the same register: claim wins, busy[i] stays 1 (a new producer supersedes the retiring one).
  - Claim of an already-busy register: stays 1, no error.
  - ZERO_REG=1: claims of register 0 are ignored; busy[0] is always 0.
- busy1/busy2: the current registered busy bits of rega/regb. No bypass of same-cycle claim or release.
- busy_cnt: registered popcount of the next-state busy vector, so it always equals the popcount of the busy bits visible in the same cycle. Range 0..NREGS; cannot wrap.
- err_wb:
  - Set on posedge clk when write_en and busy[wreg]==0 before the edge, unless ZERO_REG=1 and wreg==0.
  - Stays set until rst. A same-cycle claim of wreg does not suppress the error.
- Latency: data written at edge N is readable in cycle N+1 (cycle N with BYPASS=1). Claim/release visible on busy outputs in cycle N+1.
- No simulation-only monitors or initial blocks in RTL; all initial state comes from rst.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W_DEF, NREGS_DEF and the register-index typedef reg_idx_t.
  - R0_INIT_DEF, shared with the decoder's constant-one convention.
- One natural sub-module: regfile_scoreboard (busy vector, busy_cnt, err_wb), instantiated inside regfile_sb. The data array and bypass muxes stay in the top.

Test Plan:
- Reset, defaults: assert rst mid-run with regs dirty -> read1(rega=0)=0x0001, all other regs 0, busy1=busy2=0, busy_cnt=0, err_wb=0, all immediately without a clock edge.
- Bypass: BYPASS=1; write_en=1, wreg=3, writedata=0xBEEF, rega=3 in the same cycle -> read1=0xBEEF that cycle. BYPASS=0, same stimulus -> old value 0x0000 that cycle, 0xBEEF the next.
- Claim/release: claim r5 at edge 1 -> busy_cnt=1, busy1=1 with rega=5. Write r5=0x1234 at edge 2 -> busy=0, busy_cnt=0, read1=0x1234, err_wb=0.
- Simultaneous claim and write on r2 (r2 busy) -> r2 data updated, busy stays 1, busy_cnt unchanged, err_wb=0.
- Unclaimed writeback: write r6 with busy[6]=0 -> err_wb=1 next cycle, still 1 after further legal traffic, cleared only by rst.
- ZERO_REG=1: write r0=0xFFFF and claim r0 -> read r0=0x0000, busy=0, busy_cnt=0, err_wb=0. Fill all NREGS-1 other registers via claims -> busy_cnt=NREGS-1.
